// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: default widths, sweep
// mode encodings and the controller state encoding.
package dds_pkg;

  localparam int KW_DEF = 32;
  localparam int PW_DEF = 11;
  localparam int DW_DEF = 16;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_SAW     = 2'b01;
  localparam logic [1:0] MODE_TRI     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DWELL = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/dds_trig_sync.sv
// Brings an asynchronous trigger into the clk domain through two flops and
// turns its rising edge into a single-cycle pulse.
module dds_trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-stage synchroniser followed by a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep controller feeding a DDS phase accumulator.
// Produces the frequency word K and phase offset P, stepping K from a start
// word to a stop word with a programmable dwell per step, in one-shot,
// sawtooth or triangle mode.
// Build option: define DDS_SWEEP_TRIG_EN to add the asynchronous ext_trig
// input, whose synchronised rising edge acts as an extra start trigger.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
`ifdef DDS_SWEEP_TRIG_EN
  input  logic          ext_trig,
`endif
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          step_tick,
  output logic          sweep_done
);

  state_e        state_q;
  logic [KW-1:0] kStart_q, kStop_q, kStep_q;
  logic [KW-1:0] kStart_d, kStop_d, kStep_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;

  logic [KW-1:0] k_q;
  logic [PW-1:0] p_q;
  logic [DW-1:0] cnt_q;
  logic          down_q;
  logic          busy_q;
  logic          tick_q;
  logic          done_q;

  logic          cfgFire;
  logic          trigger;
  logic          go;
  logic [KW:0]   upSum;
  logic [KW:0]   dnDiff;
  logic [KW-1:0] kUp;
  logic [KW-1:0] kDown;
  logic [KW-1:0] kExp;
  logic          downExp;
  logic          finish;

  assign cfg_ready = (state_q == ST_IDLE);
  assign cfgFire   = cfg_valid & cfg_ready;

`ifdef DDS_SWEEP_TRIG_EN
  logic trigEdge;

  dds_trig_sync u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ext_trig),
    .edge_o  (trigEdge)
  );

  assign trigger = start | trigEdge;
`else
  assign trigger = start;
`endif

  assign go = trigger & ~abort;

  // Next shadow configuration: sanitised new values on a handshake, else hold
  always_comb begin
    kStart_d = kStart_q;
    kStop_d  = kStop_q;
    kStep_d  = kStep_q;
    dwell_d  = dwell_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    if (cfgFire) begin
      kStart_d = cfg_k_start;
      kStop_d  = (cfg_k_stop < cfg_k_start) ? cfg_k_start : cfg_k_stop;
      kStep_d  = cfg_k_step;
      dwell_d  = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
      phase_d  = cfg_phase;
      mode_d   = cfg_mode;
    end
  end

  // Shadow configuration registers, only change while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kStart_q <= '0;
      kStop_q  <= '0;
      kStep_q  <= '0;
      dwell_q  <= '0;
      phase_q  <= '0;
      mode_q   <= MODE_ONESHOT;
    end else begin
      kStart_q <= kStart_d;
      kStop_q  <= kStop_d;
      kStep_q  <= kStep_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
    end
  end

  // Saturating step arithmetic, one bit wider so neither direction wraps
  always_comb begin
    upSum  = {1'b0, k_q} + {1'b0, kStep_q};
    dnDiff = {1'b0, k_q} - {1'b0, kStep_q};
    kUp    = (upSum > {1'b0, kStop_q}) ? kStop_q : upSum[KW-1:0];
    kDown  = (dnDiff[KW] || (dnDiff[KW-1:0] < kStart_q)) ? kStart_q : dnDiff[KW-1:0];
  end

  // What happens when a dwell expires: new K, new direction, or completion
  always_comb begin
    kExp    = k_q;
    downExp = down_q;
    finish  = 1'b0;
    if (down_q) begin
      if (k_q == kStart_q) begin
        downExp = 1'b0;
        kExp    = kUp;
      end else begin
        kExp    = kDown;
      end
    end else if (k_q == kStop_q) begin
      if (mode_q == MODE_SAW) begin
        kExp = kStart_q;
      end else if (mode_q == MODE_TRI) begin
        downExp = 1'b1;
        kExp    = kDown;
      end else begin
        finish = 1'b1;
      end
    end else begin
      kExp = kUp;
    end
  end

  // Sweep state machine with registered outputs; abort overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tick_q <= 1'b0;
          done_q <= 1'b0;
          if (go) begin
            state_q <= ST_DWELL;
            k_q     <= kStart_d;
            p_q     <= phase_d;
            cnt_q   <= dwell_d - DW'(1);
            down_q  <= 1'b0;
            busy_q  <= 1'b1;
            tick_q  <= 1'b1;
          end
        end
        ST_DWELL: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - DW'(1);
            tick_q <= 1'b0;
          end else if (finish) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            tick_q  <= 1'b0;
          end else begin
            k_q    <= kExp;
            down_q <= downExp;
            tick_q <= (kExp != k_q);
            cnt_q  <= dwell_q - DW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tick_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tick_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign K          = k_q;
  assign P          = p_q;
  assign busy       = busy_q;
  assign step_tick  = tick_q;
  assign sweep_done = done_q;

endmodule
